ifid_skid_stage: RTL and testbench
==================================

// Module: ifid_skid_stage
// PURPOSE
//  Parametrised IF/ID pipeline stage with a valid/ready handshake and a 2-entry skid buffer.
//  It accepts {PC, instruction} from fetch and decodes the fixed WISC-S15 fields.
//  It supports stall via downstream backpressure and flush (squash) on branch/call redirect.
//  It sits between the fetch unit and the decode/control unit, replacing the counter-gated IF/ID register.
// PARAMETERS
//  PC_W      16       width of program counter carried through the stage
//  INST_W    16       instruction width; must be >=16, fields taken from bits [15:0]
//  NOP_INST  16'h0000 instruction loaded on reset/flush (all decoded fields derive from it)
// PORTS
//  clk            in   1       rising-edge clock
//  rst            in   1       asynchronous active-high reset
//  in_valid       in   1       fetch presents a valid {pc_in, instruction}
//  in_ready       out  1       stage can accept; registered (= !skid_valid)
//  pc_in          in   PC_W    PC of fetched instruction
//  instruction    in   INST_W  fetched instruction word
//  flush          in   1       synchronous squash of all held and incoming entries
//  out_valid      out  1       decoded entry valid for decode stage
//  out_ready      in   1       decode stage accepts entry (low = stall)
//  pc_out         out  PC_W    PC of presented entry
//  cntrl_input    out  4       inst[15:12] opcode
//  reg_rd         out  4       inst[11:8]
//  reg_rs         out  4       inst[7:4]
//  reg_rt         out  4       inst[3:0]
//  arith_imm      out  4       inst[3:0]
//  load_save_imm  out  8       inst[7:0]
//  call           out  12      inst[11:0]
//  squashed       out  1       one-cycle pulse: flush discarded >=1 valid entry
// BEHAVIOUR
//  - Storage: main reg {pc,inst,valid} drives all outputs; skid reg {pc,inst,valid} holds overflow.
//  - Decoded outputs are combinational slices of the main instruction reg; no extra latency.
//  - Transfer-in = in_valid & in_ready; transfer-out = out_valid & out_ready.
//  - Latency: entry accepted at edge N is presented with out_valid=1 after edge N (1 cycle).
//  - States (encoded by valid bits):
//    EMPTY (main=0, skid=0), ONE (main=1, skid=0), TWO (main=1, skid=1).
//  - EMPTY: xfer-in -> load main, go ONE; else stay.
//  - ONE: in&out -> load main with new entry, stay ONE; out only -> EMPTY;
//    in only (out_ready=0) -> load skid, go TWO; neither -> hold.
//  - TWO: in_ready=0; xfer-out -> main<=skid, skid invalid, go ONE; else hold all.
//  - in_ready is registered: 1 in EMPTY/ONE, 0 in TWO; never combinationally depends on out_ready.
//  - Held data never changes while out_valid=1 and out_ready=0 (stable-under-stall).
//  - flush: highest priority over all transfers in the same cycle.
//    Next state is EMPTY; main/skid inst <= NOP_INST; pc <= 0; any in_valid that cycle is dropped.
//    squashed=1 next cycle iff main or skid was valid at the flush edge.
//  - flush with out_valid & out_ready in the same cycle: the out transfer still completes
//    (consumer saw it); this is not counted as squashed if it was the only entry.
//  - Reset (async, any time incl. mid-transfer): out_valid=0, skid_valid=0, in_ready=1,
//    squashed=0, pc_out=0, inst=NOP_INST (so cntrl_input=NOP_INST[15:12], etc.).
//  - On deassertion of rst, the first edge may accept input.
//  - INST_W>16: upper bits are carried but not decoded.
// TESTING
//  1 reset mid-stream: rst pulse while TWO -> out_valid=0, in_ready=1, pc_out=0, all fields from 16'h0000
//  2 streaming: in_valid=1 each cycle, out_ready=1, pc 0x0010..0x0013, inst 0x1234 ->
//    out 1 cycle later in order, cntrl_input=1, reg_rd=2, reg_rs=3, reg_rt=4, call=0x234
//  3 stall: out_ready=0 after 2 accepts (pc 0x20, 0x21) -> in_ready=0 next cycle, pc_out holds 0x20;
//    release -> 0x20 then 0x21 delivered, none lost/duplicated
//  4 flush in TWO: pc 0x30/0x31 held, flush=1 with in_valid (pc 0x32) ->
//    next cycle out_valid=0, squashed=1, in_ready=1, pc 0x32 never emerges
//  5 flush+out transfer same cycle with only main valid (pc 0x40) ->
//    0x40 consumed, squashed=0, EMPTY
//  6 random valid/ready/flush for 10k cycles vs scoreboard model -> order, no loss/dup, stable-under-stall

Source files
------------

// File: rtl/ifid_skid_stage.sv
// ifid_skid_stage: IF/ID pipeline stage with valid/ready handshake, 2-entry skid buffer,
// flush/squash on redirect, and combinational decode of the fixed WISC-S15 fields.
module ifid_skid_stage #(
  parameter int PC_W = 16,
  parameter int INST_W = 16,
  parameter logic [INST_W-1:0] NOP_INST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [INST_W-1:0] instruction,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   pc_out,
  output logic [3:0]        cntrl_input,
  output logic [3:0]        reg_rd,
  output logic [3:0]        reg_rs,
  output logic [3:0]        reg_rt,
  output logic [3:0]        arith_imm,
  output logic [7:0]        load_save_imm,
  output logic [11:0]       call,
  output logic              squashed
);
  logic              main_valid, skid_valid;
  logic [PC_W-1:0]   main_pc, skid_pc;
  logic [INST_W-1:0] main_inst, skid_inst;
  logic              xin, xout;
  assign in_ready      = !skid_valid;
  assign out_valid     = main_valid;
  assign xin           = in_valid & in_ready;
  assign xout          = main_valid & out_ready;
  assign pc_out        = main_pc;
  assign cntrl_input   = main_inst[15:12];
  assign reg_rd        = main_inst[11:8];
  assign reg_rs        = main_inst[7:4];
  assign reg_rt        = main_inst[3:0];
  assign arith_imm     = main_inst[3:0];
  assign load_save_imm = main_inst[7:0];
  assign call          = main_inst[11:0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_pc    <= '0;
      skid_pc    <= '0;
      main_inst  <= NOP_INST;
      skid_inst  <= NOP_INST;
      squashed   <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_pc    <= '0;
      skid_pc    <= '0;
      main_inst  <= NOP_INST;
      skid_inst  <= NOP_INST;
      // a main entry consumed this same cycle was delivered, not squashed
      squashed   <= skid_valid | (main_valid & !out_ready);
    end else begin
      squashed <= 1'b0;
      if (skid_valid) begin
        if (xout) begin
          main_pc    <= skid_pc;
          main_inst  <= skid_inst;
          skid_valid <= 1'b0;
        end
      end else if (xin & (!main_valid | out_ready)) begin
        main_pc    <= pc_in;
        main_inst  <= instruction;
        main_valid <= 1'b1;
      end else if (xin) begin
        skid_pc    <= pc_in;
        skid_inst  <= instruction;
        skid_valid <= 1'b1;
      end else if (xout) begin
        main_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ifid_skid_stage.sv
// tb_ifid_skid_stage: directed vector table, reset mid-stream sequence and a
// randomized run against a queue-based reference of the skid stage.
module tb_ifid_skid_stage;
  logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready, squashed;
  logic [15:0] pc_in, instruction, pc_out;
  logic [3:0]  cntrl_input, reg_rd, reg_rs, reg_rt, arith_imm;
  logic [7:0]  load_save_imm;
  logic [11:0] call;
  int vecs = 0, errs = 0;

  ifid_skid_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc_in(pc_in),
    .instruction(instruction), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .cntrl_input(cntrl_input), .reg_rd(reg_rd), .reg_rs(reg_rs),
    .reg_rt(reg_rt), .arith_imm(arith_imm), .load_save_imm(load_save_imm), .call(call),
    .squashed(squashed)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    logic iv; logic [15:0] pc; logic [15:0] inst; logic fl; logic ordy;
    logic ov; logic ir; logic sq; logic cd; logic [15:0] epc; logic [15:0] einst;
  } vec_t;
  typedef struct packed { logic [15:0] pc; logic [15:0] inst; } ent_t;

  vec_t tbl[16];
  ent_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_fields(input string tag, input logic [15:0] epc, input logic [15:0] e);
    chk({tag, "_pc"}, 32'(pc_out), 32'(epc));
    chk({tag, "_op"}, 32'(cntrl_input), 32'(e >> 12));
    chk({tag, "_rd"}, 32'(reg_rd), 32'((e >> 8) & 16'hf));
    chk({tag, "_rs"}, 32'(reg_rs), 32'((e >> 4) & 16'hf));
    chk({tag, "_rt"}, 32'(reg_rt), 32'(e & 16'hf));
    chk({tag, "_aimm"}, 32'(arith_imm), 32'(e % 16));
    chk({tag, "_lsimm"}, 32'(load_save_imm), 32'(e % 256));
    chk({tag, "_call"}, 32'(call), 32'(e % 4096));
  endtask

  initial begin
    rst = 1; in_valid = 0; flush = 0; out_ready = 0; pc_in = 0; instruction = 0;
    //           iv  pc      inst     fl ordy ov ir sq cd epc     einst
    tbl[0]  = '{1, 16'h10, 16'h1234, 0, 1, 1, 1, 0, 1, 16'h10, 16'h1234};
    tbl[1]  = '{1, 16'h11, 16'h1234, 0, 1, 1, 1, 0, 1, 16'h11, 16'h1234};
    tbl[2]  = '{1, 16'h12, 16'h1234, 0, 1, 1, 1, 0, 1, 16'h12, 16'h1234};
    tbl[3]  = '{1, 16'h13, 16'h1234, 0, 1, 1, 1, 0, 1, 16'h13, 16'h1234};
    tbl[4]  = '{0, 16'h00, 16'h0000, 0, 1, 0, 1, 0, 0, 16'h00, 16'h0000};
    tbl[5]  = '{1, 16'h20, 16'h5678, 0, 0, 1, 1, 0, 1, 16'h20, 16'h5678};
    tbl[6]  = '{1, 16'h21, 16'h9abc, 0, 0, 1, 0, 0, 1, 16'h20, 16'h5678};
    tbl[7]  = '{1, 16'h22, 16'hdead, 0, 0, 1, 0, 0, 1, 16'h20, 16'h5678};
    tbl[8]  = '{0, 16'h00, 16'h0000, 0, 1, 1, 1, 0, 1, 16'h21, 16'h9abc};
    tbl[9]  = '{0, 16'h00, 16'h0000, 0, 1, 0, 1, 0, 0, 16'h00, 16'h0000};
    tbl[10] = '{1, 16'h30, 16'h1111, 0, 0, 1, 1, 0, 1, 16'h30, 16'h1111};
    tbl[11] = '{1, 16'h31, 16'h2222, 0, 0, 1, 0, 0, 1, 16'h30, 16'h1111};
    tbl[12] = '{1, 16'h32, 16'h7777, 1, 0, 0, 1, 1, 1, 16'h00, 16'h0000};
    tbl[13] = '{0, 16'h00, 16'h0000, 0, 1, 0, 1, 0, 1, 16'h00, 16'h0000};
    tbl[14] = '{1, 16'h40, 16'h3333, 0, 0, 1, 1, 0, 1, 16'h40, 16'h3333};
    tbl[15] = '{0, 16'h00, 16'h0000, 1, 1, 0, 1, 0, 1, 16'h00, 16'h0000};
    #12;
    chk("rst_ov", 32'(out_valid), 0);
    chk("rst_ir", 32'(in_ready), 1);
    chk("rst_sq", 32'(squashed), 0);
    chk_fields("rst", 16'h0, 16'h0);
    rst = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid = tbl[i].iv; pc_in = tbl[i].pc; instruction = tbl[i].inst;
      flush = tbl[i].fl; out_ready = tbl[i].ordy;
      @(posedge clk); #1;
      chk($sformatf("v%0d_ov", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("v%0d_ir", i), 32'(in_ready), 32'(tbl[i].ir));
      chk($sformatf("v%0d_sq", i), 32'(squashed), 32'(tbl[i].sq));
      if (tbl[i].cd) chk_fields($sformatf("v%0d", i), tbl[i].epc, tbl[i].einst);
    end
    // reset while two entries are held
    flush = 0; out_ready = 0; in_valid = 1; pc_in = 16'h60; instruction = 16'hfedc;
    @(posedge clk); #1;
    pc_in = 16'h61; instruction = 16'hba98;
    @(posedge clk); #1;
    chk("two_ir", 32'(in_ready), 0);
    in_valid = 0;
    #2 rst = 1;
    #1;
    chk("mrst_ov", 32'(out_valid), 0);
    chk("mrst_ir", 32'(in_ready), 1);
    chk("mrst_sq", 32'(squashed), 0);
    chk_fields("mrst", 16'h0, 16'h0);
    #2 rst = 0;
    in_valid = 1; pc_in = 16'h55; instruction = 16'h4321; out_ready = 1;
    @(posedge clk); #1;
    chk("post_rst_ov", 32'(out_valid), 1);
    chk_fields("post_rst", 16'h55, 16'h4321);
    in_valid = 0;
    @(posedge clk); #1;
    chk("drain_ov", 32'(out_valid), 0);
    // randomized run against the queue reference
    for (int c = 0; c < 10000; c++) begin
      logic iv, ordy, fl, exp_sq;
      int sz;
      iv = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 31) == 0);
      in_valid = iv; out_ready = ordy; flush = fl;
      pc_in = 16'($urandom); instruction = 16'($urandom);
      sz = q.size();
      @(posedge clk); #1;
      if (fl) begin
        if (sz > 0 && ordy) void'(q.pop_front());
        exp_sq = (q.size() > 0);
        q.delete();
      end else begin
        exp_sq = 0;
        if (sz > 0 && ordy) void'(q.pop_front());
        if (iv && sz < 2) q.push_back('{pc: pc_in, inst: instruction});
      end
      chk($sformatf("r%0d_ov", c), 32'(out_valid), 32'(q.size() > 0));
      chk($sformatf("r%0d_ir", c), 32'(in_ready), 32'(q.size() < 2));
      chk($sformatf("r%0d_sq", c), 32'(squashed), 32'(exp_sq));
      if (q.size() > 0) chk_fields($sformatf("r%0d", c), q[0].pc, q[0].inst);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
